// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the decoder/datapath and the multi-cycle control unit.
// With CTRL_MEM_WAIT_EN defined the bus also carries mem_ready from data memory.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       opfn;
`ifdef CTRL_MEM_WAIT_EN
  logic             mem_ready;
`endif
  logic             nia;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src;
  logic [2:0]       alu_fn;
  logic             mem_write;
  logic             mem_read;
  logic             mem_to_reg;
  logic             pc_en;
  logic             halted;
  logic             illegal_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

`ifdef CTRL_MEM_WAIT_EN
  modport master (
    input  opfn, mem_ready,
    output nia, reg_dst, reg_write, alu_src, alu_fn, mem_write, mem_read,
           mem_to_reg, pc_en, halted, illegal_op, state, instr_count
  );
  modport slave (
    output opfn, mem_ready,
    input  nia, reg_dst, reg_write, alu_src, alu_fn, mem_write, mem_read,
           mem_to_reg, pc_en, halted, illegal_op, state, instr_count
  );
`else
  modport master (
    input  opfn,
    output nia, reg_dst, reg_write, alu_src, alu_fn, mem_write, mem_read,
           mem_to_reg, pc_en, halted, illegal_op, state, instr_count
  );
  modport slave (
    output opfn,
    input  nia, reg_dst, reg_write, alu_src, alu_fn, mem_write, mem_read,
           mem_to_reg, pc_en, halted, illegal_op, state, instr_count
  );
`endif
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing for the 8-bit datapath.
// Optional CTRL_MEM_WAIT_EN lets MEM stall on mem_ready.
module multicycle_control_fsm #(
  parameter int         CNT_W   = 16,
  parameter logic [4:0] HALT_OP = 5'b11111
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_ILL
  } cls_t;

  state_t           state_reg, state_next;
  logic [4:0]       opfn_q_reg;
  logic [CNT_W-1:0] count_reg;
  logic             retire;
  logic             mem_ok;
  cls_t             cls_in, cls_q;

  // HALT_OP is checked first so it wins even if it aliases a legal opcode.
  function automatic cls_t classify(input logic [4:0] op);
    cls_t c;
    if (op == HALT_OP)          c = C_HALT;
    else if (op[4:3] == 2'b00)  c = C_R;
    else if (op == 5'b01000)    c = C_ADDI;
    else if (op == 5'b01001)    c = C_LW;
    else if (op == 5'b01010)    c = C_SW;
    else if (op == 5'b01011)    c = C_BEQ;
    else if (op == 5'b01100)    c = C_J;
    else                        c = C_ILL;
    return c;
  endfunction

  assign cls_in = classify(bus.opfn);
  assign cls_q  = classify(opfn_q_reg);

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    retire         = 1'b0;
    bus.nia        = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_fn     = 3'b000;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.pc_en      = 1'b0;
    bus.halted     = 1'b0;
    bus.illegal_op = 1'b0;

    // ALU controls are held from EXEC to the final state so operands stay stable.
    if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
      case (cls_q)
        C_R:                 begin bus.alu_fn = opfn_q_reg[2:0]; bus.alu_src = 1'b0; end
        C_ADDI, C_LW, C_SW:  begin bus.alu_fn = 3'b000;          bus.alu_src = 1'b1; end
        C_BEQ:               begin bus.alu_fn = 3'b001;          bus.alu_src = 1'b0; end
        default:             begin bus.alu_fn = 3'b000;          bus.alu_src = 1'b0; end
      endcase
    end

    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (cls_in)
          C_HALT: state_next = S_HALT;
          C_ILL: begin
            bus.illegal_op = 1'b1;
            bus.pc_en      = 1'b1;
            state_next     = S_FETCH;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        bus.nia = (cls_q == C_J);
        if (cls_q == C_BEQ || cls_q == C_J) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (cls_q == C_LW || cls_q == C_SW) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        bus.mem_read  = (cls_q == C_LW);
        bus.mem_write = (cls_q == C_SW) && mem_ok;
        if (mem_ok) begin
          if (cls_q == C_SW) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = (cls_q == C_R);
        bus.mem_read   = (cls_q == C_LW);
        bus.mem_to_reg = (cls_q == C_LW);
        retire         = 1'b1;
        state_next     = S_FETCH;
      end
      S_HALT: bus.halted = 1'b1;
      default: state_next = S_FETCH;
    endcase

    if (retire) bus.pc_en = 1'b1;

    // Abandon the in-flight instruction immediately while reset is held.
    if (rst) begin
      bus.nia        = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src    = 1'b0;
      bus.alu_fn     = 3'b000;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.pc_en      = 1'b0;
      bus.halted     = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_FETCH;
      opfn_q_reg <= 5'b00000;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) opfn_q_reg <= bus.opfn;
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bus.state       = state_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction-stream bench for multicycle_control_fsm, checked per cycle
// against an instruction-level reference model (path tables per opcode class).
module tb_multicycle_control_fsm;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(CW)) bus ();
  multicycle_control_fsm #(.CNT_W(CW), .HALT_OP(5'b11111)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL, K_HALT} kind_t;
  typedef struct { int st; bit rdy; } step_t;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t kind_of(input logic [4:0] op);
    case (op)
      5'b01000: return K_ADDI;
      5'b01001: return K_LW;
      5'b01010: return K_SW;
      5'b01011: return K_BEQ;
      5'b01100: return K_J;
      5'b11111: return K_HALT;
      default:  return (op < 5'd8) ? K_R : K_ILL;
    endcase
  endfunction

  // {nia, reg_dst, reg_write, alu_src, alu_fn[2:0], mem_write, mem_read, mem_to_reg, pc_en, halted, illegal_op}
  function automatic logic [13:0] ctl_now();
    return {bus.nia, bus.reg_dst, bus.reg_write, bus.alu_src, bus.alu_fn, bus.mem_write,
            bus.mem_read, bus.mem_to_reg, bus.pc_en, bus.halted, bus.illegal_op};
  endfunction

  // Expected outputs in an EXEC/MEM/WB cycle of an instruction.
  function automatic logic [13:0] exp_ctl(input kind_t k, input logic [4:0] op, input int st,
                                          input bit last, input bit rdy);
    logic [2:0] fn;
    logic src, nia, rdst, rw, mw, mr, m2r;
    fn   = (k == K_R) ? op[2:0] : (k == K_BEQ) ? 3'b001 : 3'b000;
    src  = (k == K_ADDI || k == K_LW || k == K_SW);
    nia  = (k == K_J && st == 2);
    rdst = (k == K_R && st == 4);
    rw   = (st == 4);
    mw   = (k == K_SW && st == 3 && rdy);
    mr   = (k == K_LW && (st == 3 || st == 4));
    m2r  = (k == K_LW && st == 4);
    return {nia, rdst, rw, src, fn, mw, mr, m2r, last, 1'b0, 1'b0};
  endfunction

  task automatic drive_ready(input bit r);
`ifdef CTRL_MEM_WAIT_EN
    bus.mem_ready = r;
`endif
  endtask

  // Called at posedge+1 with inputs applied; samples at negedge, returns at posedge+1.
  task automatic cycle_check(input string tag, input int exp_state, input logic [13:0] exp_c,
                             input bit inc);
    @(negedge clk);
    check_eq({tag, ".state"}, 32'(bus.state), 32'(exp_state));
    check_eq({tag, ".ctl"}, 32'(ctl_now()), 32'(exp_c));
    check_eq({tag, ".count"}, 32'(bus.instr_count), 32'(exp_count));
    @(posedge clk);
    #1;
    if (inc) exp_count = exp_count + 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.opfn = 5'($urandom);
      drive_ready(1'($urandom));
      @(posedge clk);
      #1;
      exp_count = '0;
      @(negedge clk);
      check_eq("reset.state", 32'(bus.state), 32'd0);
      check_eq("reset.ctl", 32'(ctl_now()), 32'd0);
      check_eq("reset.count", 32'(bus.instr_count), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [4:0] op, input int waits);
    kind_t k;
    step_t path[$];
    k = kind_of(op);
    $display("instr op=%b kind=%s waits=%0d count=%0d", op, k.name(), waits, exp_count);
    bus.opfn = 5'($urandom);
    drive_ready(1'($urandom));
    cycle_check("fetch", 0, 14'd0, 1'b0);
    bus.opfn = op;
    if (k == K_ILL) begin
      cycle_check("decode_ill", 1, 14'b00000000000101, 1'b0);
      return;
    end
    cycle_check("decode", 1, 14'd0, 1'b0);
    if (k == K_HALT) begin
      for (int i = 0; i < 20; i++) begin
        bus.opfn = 5'($urandom);
        drive_ready(1'($urandom));
        cycle_check("halt", 5, 14'b00000000000010, 1'b0);
      end
      return;
    end
    path.push_back('{2, 1'b1});
    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w < waits; w++) path.push_back('{3, 1'b0});
      path.push_back('{3, 1'b1});
    end
    if (k == K_R || k == K_ADDI || k == K_LW) path.push_back('{4, 1'b1});
    for (int i = 0; i < path.size(); i++) begin
      bit last;
      last = (i == path.size() - 1);
      bus.opfn = 5'($urandom);
      drive_ready(path[i].st == 3 ? path[i].rdy : 1'($urandom));
      cycle_check("exec_path", path[i].st, exp_ctl(k, op, path[i].st, last, path[i].rdy), last);
    end
  endtask

  // LW cut short by reset in MEM: no write-back may ever appear.
  task automatic run_lw_abort();
    $display("instr op=01001 kind=LW aborted by reset in MEM");
    bus.opfn = 5'($urandom);
    cycle_check("abort.fetch", 0, 14'd0, 1'b0);
    bus.opfn = 5'b01001;
    cycle_check("abort.decode", 1, 14'd0, 1'b0);
    bus.opfn = 5'($urandom);
    drive_ready(1'b0);
    cycle_check("abort.exec", 2, exp_ctl(K_LW, 5'b01001, 2, 1'b0, 1'b1), 1'b0);
    rst = 1'b1;
    drive_ready(1'b1);
    cycle_check("abort.rst_cycle", 3, 14'd0, 1'b0);
    rst = 1'b0;
    exp_count = '0;
  endtask

  function automatic logic [4:0] rand_op();
    logic [4:0] op;
    case ($urandom_range(0, 6))
      0: op = 5'($urandom_range(0, 7));
      1: op = 5'b01000;
      2: op = 5'b01001;
      3: op = 5'b01010;
      4: op = 5'b01011;
      5: op = 5'b01100;
      default: begin
        op = 5'b01101 + 5'($urandom_range(0, 17));
      end
    endcase
    return op;
  endfunction

  function automatic int rand_waits();
`ifdef CTRL_MEM_WAIT_EN
    return $urandom_range(0, 3);
`else
    return 0;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    bus.opfn = 5'b00000;
    drive_ready(1'b1);
    exp_count = '0;
    do_reset(2);

    bus.opfn = 5'b00000;
    run_instr(5'b00000, 0);
    check_eq("add_count", 32'(bus.instr_count), 32'd1);
    run_instr(5'b01001, 0);
    run_instr(5'b01010, 0);
    run_instr(5'b01011, 0);
    run_instr(5'b01100, 0);
    run_instr(5'b01111, 0);
    run_instr(5'b11110, 0);
`ifdef CTRL_MEM_WAIT_EN
    run_instr(5'b01010, 3);
    run_instr(5'b01001, 2);
`endif

    for (int n = 0; n < 400; n++) run_instr(rand_op(), rand_waits());

    run_lw_abort();
    for (int n = 0; n < 20; n++) run_instr(rand_op(), rand_waits());

    run_instr(5'b11111, 0);
    do_reset(1);
    run_instr(5'b00101, 0);
    check_eq("post_halt_count", 32'(bus.instr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
